// File: rtl/raycast_pkg.sv
// raycast_pkg: shared write-FSM states and default sky/floor colours for the column renderer.
package raycast_pkg;
   typedef enum logic {FILL, PENDING} wr_state_t;
   localparam int DEF_CEIL_COLOR  = 0;
   localparam int DEF_FLOOR_COLOR = 0;
endpackage

// File: rtl/raycast_column_renderer_if.sv
// raycast_column_renderer_if: raycaster column-write port plus display pixel-read port.
interface raycast_column_renderer_if #(
   parameter int COL_W    = 10,
   parameter int HEIGHT_W = 10,
   parameter int COLOR_W  = 6
);
   logic                i_wr_valid;
   logic                o_wr_ready;
   logic [COL_W-1:0]    i_wr_col;
   logic [HEIGHT_W-1:0] i_wr_height;
   logic [COLOR_W-1:0]  i_wr_color;
   logic                i_wr_last;
   logic                i_frame_start;
   logic                i_pix_en;
   logic [9:0]          i_x;
   logic [9:0]          i_y;
   logic [COLOR_W-1:0]  o_pixel;
   logic                o_pix_valid;
   logic                o_front_sel;
   logic                o_swap_pending;
   modport master (
      output i_wr_valid, i_wr_col, i_wr_height, i_wr_color, i_wr_last, i_frame_start,
      output i_pix_en, i_x, i_y,
      input  o_wr_ready, o_pixel, o_pix_valid, o_front_sel, o_swap_pending
   );
   modport slave (
      input  i_wr_valid, i_wr_col, i_wr_height, i_wr_color, i_wr_last, i_frame_start,
      input  i_pix_en, i_x, i_y,
      output o_wr_ready, o_pixel, o_pix_valid, o_front_sel, o_swap_pending
   );
endinterface

// File: rtl/raycast_col_ram.sv
// raycast_col_ram: simple dual-port column store, bank bit is the address MSB, registered read.
module raycast_col_ram #(
   parameter int AW = 11,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   // Address space is 2 x 2**(AW-1); only the first H_RES slots of each bank are ever written.
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/raycast_column_renderer.sv
// raycast_column_renderer: double-buffered wall-column store with swap-at-vblank and a
// 2-stage pixel pipeline that turns {height, colour} into ceiling / wall / floor pixels.
module raycast_column_renderer
   import raycast_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_CENTER    = 240,
   parameter int HEIGHT_W    = 10,
   parameter int COLOR_W     = 6,
   parameter int H_SHIFT     = 2,
   parameter int CEIL_COLOR  = DEF_CEIL_COLOR,
   parameter int FLOOR_COLOR = DEF_FLOOR_COLOR
) (
   input logic i_clk,
   input logic i_rst,
   raycast_column_renderer_if.slave bus
);
   localparam int COL_W = $clog2(H_RES);
   localparam int DW    = HEIGHT_W + COLOR_W;
   localparam int PW    = HEIGHT_W + 1;
   wr_state_t state, state_n;
   logic front, front_n, we;
   logic [DW-1:0] rdata;
   logic v1, xok1, pix_valid;
   logic [9:0] y1;
   logic [COLOR_W-1:0] pixel, pix_n;
   logic [HEIGHT_W-1:0] h;
   logic [COLOR_W-1:0] c;
   logic [PW-1:0] half, top, bot, yy;
   logic wall, ceil;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= FILL;
         front <= 1'b0;
      end else begin
         state <= state_n;
         front <= front_n;
      end
   end
   // A frame_start seen in FILL is ignored; the swap waits for the next one after PENDING.
   always_comb begin
      state_n = (state == FILL) ? ((bus.i_wr_valid && bus.i_wr_last) ? PENDING : FILL)
                                : (bus.i_frame_start ? FILL : PENDING);
      front_n = front ^ (state == PENDING && bus.i_frame_start);
   end
   assign bus.o_wr_ready     = state == FILL;
   assign bus.o_swap_pending = state == PENDING;
   assign bus.o_front_sel    = front;
   assign we = bus.i_wr_valid && state == FILL && int'(bus.i_wr_col) < H_RES;
   raycast_col_ram #(.AW(COL_W + 1), .DW(DW)) u_ram (
      .clk   (i_clk),
      .we    (we),
      .waddr ({~front, bus.i_wr_col}),
      .wdata ({bus.i_wr_height, bus.i_wr_color}),
      .raddr ({front, bus.i_x[COL_W-1:0]}),
      .rdata (rdata)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1        <= 1'b0;
         pix_valid <= 1'b0;
         pixel     <= '0;
      end else begin
         v1        <= bus.i_pix_en;
         pix_valid <= v1;
         pixel     <= v1 ? pix_n : '0;
      end
      xok1 <= int'(bus.i_x) < H_RES;
      y1   <= bus.i_y;
   end
   always_comb begin
      h    = rdata[DW-1:COLOR_W];
      c    = rdata[COLOR_W-1:0];
      half = PW'(h >> H_SHIFT);
      top  = (half > PW'(V_CENTER)) ? '0 : PW'(V_CENTER) - half;
      bot  = PW'(V_CENTER) + half;
      yy   = PW'(y1);
      wall = h != 0 && yy >= top && yy <= bot;
      ceil = yy < top || (h == 0 && yy < PW'(V_CENTER));
      pix_n = !xok1 ? '0 : wall ? c : ceil ? COLOR_W'(CEIL_COLOR) : COLOR_W'(FLOOR_COLOR);
   end
   assign bus.o_pix_valid = pix_valid;
   assign bus.o_pixel     = pixel;
endmodule

// File: tb/tb_raycast_column_renderer.sv
// tb_raycast_column_renderer: directed bench for bank fill/swap, pixel shading and reset.
module tb_raycast_column_renderer;
   localparam int CEIL  = 'h03;
   localparam int FLOOR = 'h3C;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   raycast_column_renderer_if #(.COL_W(10), .HEIGHT_W(10), .COLOR_W(6)) bus ();
   raycast_column_renderer #(.CEIL_COLOR(CEIL), .FLOOR_COLOR(FLOOR)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic wr(input int col, input int ht, input int color, input logic last);
      @(negedge clk);
      bus.i_wr_valid  = 1'b1;
      bus.i_wr_col    = 10'(col);
      bus.i_wr_height = 10'(ht);
      bus.i_wr_color  = 6'(color);
      bus.i_wr_last   = last;
      @(negedge clk);
      bus.i_wr_valid = 1'b0;
      bus.i_wr_last  = 1'b0;
   endtask
   task automatic pulse_fs();
      @(negedge clk);
      bus.i_frame_start = 1'b1;
      @(negedge clk);
      bus.i_frame_start = 1'b0;
   endtask
   task automatic pix(input string tag, input int x, input int y, input int exp);
      @(negedge clk);
      bus.i_pix_en = 1'b1;
      bus.i_x = 10'(x);
      bus.i_y = 10'(y);
      @(negedge clk);
      bus.i_pix_en = 1'b0;
      chk({tag, "_lat1"}, 32'(bus.o_pix_valid), 0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.o_pix_valid), 1);
      chk(tag, 32'(bus.o_pixel), 32'(exp));
   endtask
   initial begin
      rst = 1'b1;
      bus.i_wr_valid = 1'b0; bus.i_wr_col = '0; bus.i_wr_height = '0; bus.i_wr_color = '0;
      bus.i_wr_last = 1'b0; bus.i_frame_start = 1'b0; bus.i_pix_en = 1'b0; bus.i_x = '0; bus.i_y = '0;
      repeat (2) @(negedge clk);
      chk("rst_front", 32'(bus.o_front_sel), 0);
      chk("rst_valid", 32'(bus.o_pix_valid), 0);
      chk("rst_pixel", 32'(bus.o_pixel), 0);
      chk("rst_ready", 32'(bus.o_wr_ready), 1);
      chk("rst_pend", 32'(bus.o_swap_pending), 0);
      rst = 1'b0;
      wr(5, 160, 'h2A, 1'b0);
      wr(0, 1023, 'h15, 1'b0);
      wr(639, 0, 'h11, 1'b1);
      chk("pend_ready", 32'(bus.o_wr_ready), 0);
      chk("pend_flag", 32'(bus.o_swap_pending), 1);
      chk("pend_front", 32'(bus.o_front_sel), 0);
      @(negedge clk);
      bus.i_wr_valid = 1'b1; bus.i_wr_col = 10'd5; bus.i_wr_height = 10'd4; bus.i_wr_color = 6'h07;
      repeat (2) @(negedge clk);
      chk("hold_ready", 32'(bus.o_wr_ready), 0);
      bus.i_wr_valid = 1'b0;
      pulse_fs();
      chk("swap_front", 32'(bus.o_front_sel), 1);
      chk("swap_ready", 32'(bus.o_wr_ready), 1);
      chk("swap_pend", 32'(bus.o_swap_pending), 0);
      pix("c5_y200", 5, 200, 'h2A);
      pix("c5_y240", 5, 240, 'h2A);
      pix("c5_y280", 5, 280, 'h2A);
      pix("c5_y199", 5, 199, CEIL);
      pix("c5_y281", 5, 281, FLOOR);
      pix("c5_y0", 5, 0, CEIL);
      pix("c0_y0", 0, 0, 'h15);
      pix("c0_y495", 0, 495, 'h15);
      pix("c0_y496", 0, 496, FLOOR);
      pix("c639_y100", 639, 100, CEIL);
      pix("c639_y240", 639, 240, FLOOR);
      pix("x700", 700, 240, 0);
      wr(5, 8, 'h09, 1'b0);
      @(negedge clk);
      bus.i_wr_valid = 1'b1; bus.i_wr_col = 10'd639; bus.i_wr_height = 10'd0; bus.i_wr_color = 6'h11;
      bus.i_wr_last = 1'b1; bus.i_frame_start = 1'b1;
      @(negedge clk);
      bus.i_wr_valid = 1'b0; bus.i_wr_last = 1'b0; bus.i_frame_start = 1'b0;
      chk("same_cyc_front", 32'(bus.o_front_sel), 1);
      chk("same_cyc_pend", 32'(bus.o_swap_pending), 1);
      pix("pre_swap", 5, 240, 'h2A);
      @(negedge clk);
      bus.i_pix_en = 1'b1; bus.i_x = 10'd5; bus.i_y = 10'd240; bus.i_frame_start = 1'b1;
      @(negedge clk);
      bus.i_pix_en = 1'b0; bus.i_frame_start = 1'b0;
      chk("late_swap_front", 32'(bus.o_front_sel), 0);
      @(negedge clk);
      chk("inflight_valid", 32'(bus.o_pix_valid), 1);
      chk("inflight_pixel", 32'(bus.o_pixel), 'h2A);
      pix("b0_y240", 5, 240, 'h09);
      pix("b0_y242", 5, 242, 'h09);
      pix("b0_y238", 5, 238, 'h09);
      pix("b0_y243", 5, 243, FLOOR);
      pix("b0_y237", 5, 237, CEIL);
      wr(639, 0, 'h11, 1'b1);
      pulse_fs();
      chk("third_front", 32'(bus.o_front_sel), 1);
      wr(700, 100, 'h30, 1'b0);
      chk("oob_ready", 32'(bus.o_wr_ready), 1);
      chk("oob_pend", 32'(bus.o_swap_pending), 0);
      wr(639, 0, 'h11, 1'b1);
      chk("pre_rst_pend", 32'(bus.o_swap_pending), 1);
      @(negedge clk);
      bus.i_pix_en = 1'b1; bus.i_x = 10'd5; bus.i_y = 10'd240;
      @(negedge clk);
      bus.i_pix_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_front", 32'(bus.o_front_sel), 0);
      chk("mid_rst_ready", 32'(bus.o_wr_ready), 1);
      chk("mid_rst_pend", 32'(bus.o_swap_pending), 0);
      chk("mid_rst_valid", 32'(bus.o_pix_valid), 0);
      chk("mid_rst_pixel", 32'(bus.o_pixel), 0);
      pulse_fs();
      chk("no_swap_after_rst", 32'(bus.o_front_sel), 0);
      pix("post_rst", 5, 240, 'h09);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/raycast_column_renderer.md
RAYCAST_COLUMN_RENDERER -- requirements
Module: raycast_column_renderer

Interface
REQ-001 SHALL have parameter H_RES, 640, number of screen columns (column-buffer depth per bank).
REQ-002 SHALL have parameter V_CENTER, 240, horizon row.
REQ-003 SHALL have parameter HEIGHT_W, 10, width of stored wall height.
REQ-004 SHALL have parameter COLOR_W, 6, pixel/colour width.
REQ-005 SHALL have parameter H_SHIFT, 2, right-shift applied to height to get half-extent.
REQ-006 SHALL have parameters CEIL_COLOR, 0, and FLOOR_COLOR, 0, colours above and below the wall.
REQ-007 SHALL have one clock and a synchronous active-high reset: i_clk  in  1  clock; i_rst  in  1  sync reset, active high.
REQ-008 SHALL have i_wr_valid  in  1  raycaster column write valid; o_wr_ready  out  1  write accepted when both high.
REQ-009 SHALL have i_wr_col  in  $clog2(H_RES)  column index; i_wr_height  in  HEIGHT_W  wall height; i_wr_color  in  COLOR_W  wall colour; i_wr_last  in  1  final column of frame.
REQ-010 SHALL have i_frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-011 SHALL have i_pix_en  in  1  pixel request; i_x  in  10  column; i_y  in  10  row.
REQ-012 SHALL have o_pixel  out  COLOR_W  pixel colour; o_pix_valid  out  1  o_pixel valid; o_front_sel  out  1  bank being displayed; o_swap_pending  out  1  back bank complete, awaiting swap.

Function
REQ-013 SHALL hold two banks of H_RES entries {height, colour}; writes go to bank !o_front_sel, reads from bank o_front_sel.
REQ-014 SHALL use write FSM states FILL, PENDING; o_wr_ready = 1 in FILL, 0 in PENDING; o_swap_pending = 1 in PENDING.
REQ-015 SHALL, on accepted write, store entry at i_wr_col of back bank next edge; i_wr_col >= H_RES SHALL be accepted and discarded.
REQ-016 SHALL go FILL->PENDING on accepted write with i_wr_last=1.
REQ-017 SHALL go PENDING->FILL on i_frame_start, toggling o_front_sel same edge.
REQ-018 SHALL ignore i_frame_start in FILL (no swap); i_wr_last and i_frame_start in the same cycle in FILL SHALL swap only at the next i_frame_start.
REQ-019 SHALL have 2-cycle pixel latency: i_pix_en at cycle N -> o_pix_valid=1 and o_pixel at cycle N+2; i_y and bank select pipelined with the read, so a swap mid-pipeline does not corrupt in-flight pixels.
REQ-020 SHALL compute half = height >> H_SHIFT; top = max(V_CENTER - half, 0) (no underflow); bot = V_CENTER + half in HEIGHT_W+1 bits (no overflow).
REQ-021 SHALL output column colour when height != 0 and top <= y <= bot (inclusive, so row 0 is drawable); CEIL_COLOR when y < top or height = 0 and y < V_CENTER; FLOOR_COLOR otherwise.
REQ-022 SHALL output o_pixel = 0 whenever o_pix_valid = 0; i_x >= H_RES SHALL yield o_pixel = 0 with o_pix_valid = 1.
REQ-023 SHALL allow simultaneous write and read every cycle (independent ports, no stall).

Reset
REQ-024 SHALL on i_rst: state FILL, o_front_sel=0, o_pix_valid=0 and pipeline valids cleared, o_pixel=0; reset mid-frame SHALL discard pending swap.
REQ-025 SHALL not reset RAM contents; front-bank reads before first swap are undefined colour but o_pix_valid timing holds.

Structure
REQ-026 SHALL place FSM state enum and default CEIL/FLOOR colour constants in shared package raycast_pkg.
REQ-027 SHALL instantiate one sub-module raycast_col_ram: 2*H_RES-entry simple dual-port RAM, 1-cycle registered read, bank bit as address MSB.

Verification
REQ-028 Write col 5 {height=160, colour=0x2A}, last at col 639, pulse i_frame_start -> o_front_sel=1; read x=5: y=200..280 -> 0x2A, y=199 -> CEIL, y=281 -> FLOOR, each 2 cycles after i_pix_en.
REQ-029 Height 1023 at col 0 -> half=255, top clamps 0, bot=495; y=0 and y=495 -> wall colour, y=496 -> FLOOR.
REQ-030 i_wr_last accepted -> o_wr_ready=0 until i_frame_start; i_wr_valid held in PENDING writes nothing (front-bank readback unchanged).
REQ-031 i_wr_last and i_frame_start same cycle -> no toggle; toggle on next i_frame_start.
REQ-032 i_rst asserted in PENDING -> next cycle state FILL, o_front_sel=0, o_pix_valid=0, o_pixel=0; i_wr_col=700 write discarded.
